// File: rtl/win_accum_if.sv
// rtl/win_accum_if.sv - sample/result bus of the windowed accumulator (o_ovf with WIN_ACCUM_OVF_EN)
interface win_accum_if #(
  parameter int W_IN  = 3,
  parameter int W_OUT = 5
);
  logic                    i_clear;
  logic                    i_valid;
  logic signed [W_IN-1:0]  i_data;
  logic                    o_valid;
  logic signed [W_OUT-1:0] o_data;
`ifdef WIN_ACCUM_OVF_EN
  logic                    o_ovf;

  modport master (output i_clear, i_valid, i_data, input o_valid, o_data, o_ovf);
  modport slave  (input i_clear, i_valid, i_data, output o_valid, o_data, o_ovf);
`else
  modport master (output i_clear, i_valid, i_data, input o_valid, o_data);
  modport slave  (input i_clear, i_valid, i_data, output o_valid, o_data);
`endif
endinterface

// File: rtl/win_accum.sv
// rtl/win_accum.sv - windowed signed accumulator, one registered sum per LEN samples (option: WIN_ACCUM_OVF_EN)
module win_accum #(
  parameter int W_IN  = 3,
  parameter int LEN   = 4,
  parameter int W_OUT = 5
) (
  input logic         i_clk,
  input logic         i_rst_n,
  win_accum_if.slave  bus
);
  localparam int W_FULL = W_IN + $clog2(LEN);
  localparam int W_CNT  = $clog2(LEN);
  localparam logic [W_CNT-1:0] LAST = W_CNT'(LEN - 1);

  logic signed [W_FULL-1:0] acc;
  logic signed [W_FULL-1:0] sum;
  logic        [W_CNT-1:0]  cnt;
  logic signed [W_OUT-1:0]  sum_out;
  logic                     closing;
  logic                     valid_q;
  logic signed [W_OUT-1:0]  data_q;

  assign sum     = acc + {{(W_FULL - W_IN){bus.i_data[W_IN-1]}}, bus.i_data};
  assign closing = bus.i_valid && !bus.i_clear && (cnt == LAST);

  // Narrow or widen the full-precision sum to the output width.
  generate
    if (W_OUT <= W_FULL) begin : g_trunc
      assign sum_out = sum[W_OUT-1:0];
    end else begin : g_sext
      assign sum_out = {{(W_OUT - W_FULL){sum[W_FULL-1]}}, sum};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (bus.i_clear) begin
      acc     <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else if (closing) begin
      acc     <= '0;
      cnt     <= '0;
      valid_q <= 1'b1;
      data_q  <= sum_out;
    end else begin
      valid_q <= 1'b0;
      if (bus.i_valid) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;

`ifdef WIN_ACCUM_OVF_EN
  logic ovf_next;
  logic ovf_q;

  // Sum fits iff all bits from the output sign bit upward agree.
  generate
    if (W_OUT >= W_FULL) begin : g_no_ovf
      assign ovf_next = 1'b0;
    end else begin : g_ovf
      logic [W_FULL-W_OUT:0] top;
      assign top      = sum[W_FULL-1:W_OUT-1];
      assign ovf_next = !((&top) || !(|top));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else if (closing) begin
      ovf_q <= ovf_next;
    end
  end

  assign bus.o_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_win_accum.sv
// tb/tb_win_accum.sv - directed bench for win_accum with a window-sum reference model
module tb_win_accum;
  localparam int W_IN = 3;
  localparam int LEN  = 4;
`ifdef WIN_ACCUM_OVF_EN
  localparam int W_OUT  = 4;
  localparam int LIT_P12 = -4;
  localparam int LIT_N16 = 0;
`else
  localparam int W_OUT  = 5;
  localparam int LIT_P12 = 12;
  localparam int LIT_N16 = -16;
`endif

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  win_accum_if #(.W_IN(W_IN), .W_OUT(W_OUT)) bus ();

  win_accum #(.W_IN(W_IN), .LEN(LEN), .W_OUT(W_OUT)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  int                      win_sum;
  int                      win_n;
  logic                    exp_valid;
  logic signed [W_OUT-1:0] exp_data;
  logic                    exp_ovf;

  function automatic logic signed [W_OUT-1:0] wrap(input int s);
    logic [31:0] v;
    v = s;
    return v[W_OUT-1:0];
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    win_sum   = 0;
    win_n     = 0;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_ovf   = 1'b0;
  endtask

  // Drive one cycle of input, advance the model at the edge, return at the next falling edge.
  task automatic step(input bit c, input bit v, input int d);
    logic [31:0] dv;
    dv = d;
    bus.i_clear = c;
    bus.i_valid = v;
    bus.i_data  = dv[W_IN-1:0];
    @(posedge i_clk);
    exp_valid = 1'b0;
    if (c) begin
      win_sum = 0;
      win_n   = 0;
    end else if (v) begin
      win_sum += d;
      win_n++;
      if (win_n == LEN) begin
        exp_valid = 1'b1;
        exp_data  = wrap(win_sum);
        exp_ovf   = (win_sum < -(1 << (W_OUT - 1))) || (win_sum > (1 << (W_OUT - 1)) - 1);
        win_sum   = 0;
        win_n     = 0;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic samples(input int d, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, d);
  endtask

  task automatic pin(input string name, input int req);
    cmp({name, "_valid"}, int'(bus.o_valid), 1);
    cmp({name, "_data"}, int'($signed(bus.o_data)), req);
  endtask

  always @(negedge i_clk) begin
    if (run) begin
      cmp("o_valid", int'(bus.o_valid), int'(exp_valid));
      cmp("o_data", int'($signed(bus.o_data)), int'(exp_data));
`ifdef WIN_ACCUM_OVF_EN
      cmp("o_ovf", int'(bus.o_ovf), int'(exp_ovf));
`endif
    end
  end

  initial begin
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    model_reset();
    run = 1'b1;
    #1;
    cmp("reset_valid", int'(bus.o_valid), 0);
    cmp("reset_data", int'($signed(bus.o_data)), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    samples(3, 4);
    pin("win_p12", LIT_P12);
`ifdef WIN_ACCUM_OVF_EN
    cmp("ovf_p12", int'(bus.o_ovf), 1);
`endif
    samples(-4, 4);
    pin("win_n16", LIT_N16);

    samples(3, 2);
    #1 i_rst_n = 1'b0;
    #1 model_reset();
    cmp("async_rst_valid", int'(bus.o_valid), 0);
    cmp("async_rst_data", int'($signed(bus.o_data)), 0);
    #1 i_rst_n = 1'b1;
    samples(1, 4);
    pin("after_rst", 4);
`ifdef WIN_ACCUM_OVF_EN
    cmp("ovf_after_rst", int'(bus.o_ovf), 0);
`endif

    step(1'b0, 1'b1, 1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, -2);
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, -3);
    pin("gapped", -2);

    samples(2, 2);
    step(1'b1, 1'b1, 3);
    samples(1, 3);
    cmp("clear_hold", int'($signed(bus.o_data)), -2);
    samples(1, 1);
    pin("clear_coll", 4);

    samples(1, 4);
    pin("b2b_first", 4);
    samples(1, 4);
    pin("b2b_second", 4);
`ifdef WIN_ACCUM_OVF_EN
    cmp("ovf_b2b", int'(bus.o_ovf), 0);
`endif

    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    run = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
